// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with a valid/ready handshake and a two-entry skid
// buffer. The main slot drives the ex_* outputs straight from flops; the skid
// slot catches the one instruction that arrives when EX stalls. An empty stage
// always presents an all-zero payload (a nop with we=0). Flush kills both
// slots and the instruction presented on the ID side that cycle.
// Optional build macro: ID_EX_PERF_EN adds saturating stall, bubble and flush
// performance counters.
module id_ex_skid_reg #(
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_opv1,
   input  logic [DATA_W-1:0]   id_opv2,
   input  logic                id_we,
   input  logic [RADDR_W-1:0]  id_waddr,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_opv1,
   output logic [DATA_W-1:0]   ex_opv2,
   output logic                ex_we,
   output logic [RADDR_W-1:0]  ex_waddr
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]         perf_stall_cnt,
   output logic [31:0]         perf_bubble_cnt,
   output logic [15:0]         perf_flush_cnt
`endif
);

   typedef struct packed {
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   opv1;
      logic [DATA_W-1:0]   opv2;
      logic                we;
      logic [RADDR_W-1:0]  waddr;
   } payload_t;

   // Bit 0 is main_v and bit 1 is skid_v; skid-only (2'b10) is unreachable.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      M_HOLD,
      M_LOAD_ID,
      M_LOAD_SKID,
      M_CLEAR
   } main_op_t;

   typedef enum logic [1:0] {
      S_HOLD,
      S_LOAD_ID,
      S_CLEAR
   } skid_op_t;

   state_t   state_q, state_n;
   main_op_t main_op;
   skid_op_t skid_op;
   payload_t main_q, skid_q, id_pay;
   logic     main_v, skid_v, accept, consume;

   assign main_v   = state_q[0];
   assign skid_v   = state_q[1];
   assign id_ready = ~skid_v;
   assign ex_valid = main_v;
   assign accept   = id_valid & id_ready & ~flush;
   assign consume  = main_v & ex_ready;

   assign id_pay = '{aluop: id_aluop, alusel: id_alusel, opv1: id_opv1,
                     opv2: id_opv2, we: id_we, waddr: id_waddr};

   assign ex_aluop  = main_q.aluop;
   assign ex_alusel = main_q.alusel;
   assign ex_opv1   = main_q.opv1;
   assign ex_opv2   = main_q.opv2;
   assign ex_we     = main_q.we;
   assign ex_waddr  = main_q.waddr;

   // Occupancy state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_n;
   end

   // Next occupancy and the slot update each transition implies.
   always_comb begin
      state_n = state_q;
      main_op = M_HOLD;
      skid_op = S_HOLD;
      if (flush) begin
         state_n = EMPTY;
         main_op = M_CLEAR;
         skid_op = S_CLEAR;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_n = ONE;
                  main_op = M_LOAD_ID;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_op = M_LOAD_ID;
               end else if (accept) begin
                  state_n = FULL;
                  skid_op = S_LOAD_ID;
               end else if (consume) begin
                  state_n = EMPTY;
                  main_op = M_CLEAR;
               end
            end
            FULL: begin
               if (consume) begin
                  state_n = ONE;
                  main_op = M_LOAD_SKID;
                  skid_op = S_CLEAR;
               end
            end
            default: begin
               state_n = EMPTY;
               main_op = M_CLEAR;
               skid_op = S_CLEAR;
            end
         endcase
      end
   end

   // Payload slots; cleared whenever they become empty so EX sees a nop.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (main_op)
            M_LOAD_ID:   main_q <= id_pay;
            M_LOAD_SKID: main_q <= skid_q;
            M_CLEAR:     main_q <= '0;
            default:     main_q <= main_q;
         endcase
         case (skid_op)
            S_LOAD_ID: skid_q <= id_pay;
            S_CLEAR:   skid_q <= '0;
            default:   skid_q <= skid_q;
         endcase
      end
   end

`ifdef ID_EX_PERF_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   // Saturating event counters; only rst clears them, flush is itself counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt  <= '0;
         perf_bubble_cnt <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         if (id_valid && !id_ready) perf_stall_cnt  <= sat_inc32(perf_stall_cnt);
         if (!main_v && ex_ready)   perf_bubble_cnt <= sat_inc32(perf_bubble_cnt);
         if (flush)                 perf_flush_cnt  <= sat_inc16(perf_flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg. A queue of accepted instructions
// (at most two deep) is the reference: EX sees its head, ID is ready while it
// holds fewer than two, flush/reset empty it.
module tb_id_ex_skid_reg;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] opv1;
      logic [31:0] opv2;
      logic        we;
      logic [4:0]  waddr;
   } pay_t;

   logic clk = 1'b0;
   logic rst, flush, id_valid, ex_ready;
   pay_t id_pay;
   logic id_ready, ex_valid;
   logic [7:0]  ex_aluop;
   logic [2:0]  ex_alusel;
   logic [31:0] ex_opv1, ex_opv2;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   pay_t ex_pay;
`ifdef ID_EX_PERF_EN
   logic [31:0] perf_stall_cnt, perf_bubble_cnt;
   logic [15:0] perf_flush_cnt;
`endif

   int   n_cmp = 0;
   int   n_fail = 0;
   pay_t q[$];

   always #5 clk = ~clk;

   assign ex_pay = {ex_aluop, ex_alusel, ex_opv1, ex_opv2, ex_we, ex_waddr};

   id_ex_skid_reg dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(id_pay.aluop), .id_alusel(id_pay.alusel),
      .id_opv1(id_pay.opv1), .id_opv2(id_pay.opv2),
      .id_we(id_pay.we), .id_waddr(id_pay.waddr),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_opv1(ex_opv1), .ex_opv2(ex_opv2),
      .ex_we(ex_we), .ex_waddr(ex_waddr)
`ifdef ID_EX_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_bubble_cnt(perf_bubble_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   function automatic pay_t rand_pay();
      pay_t p;
      p.aluop  = 8'($urandom);
      p.alusel = 3'($urandom);
      p.opv1   = $urandom;
      p.opv2   = $urandom;
      p.we     = 1'($urandom);
      p.waddr  = 5'($urandom);
      return p;
   endfunction

   function automatic pay_t mk(input logic [7:0] aluop, input logic [31:0] opv1,
                               input logic [4:0] waddr);
      pay_t p;
      p = rand_pay();
      p.aluop = aluop;
      p.opv1  = opv1;
      p.waddr = waddr;
      p.we    = 1'b1;
      return p;
   endfunction

   // One clock edge; the reference queue steps on the inputs seen at that edge.
   task automatic tick();
      bit acc, cons;
      @(posedge clk);
      acc  = id_valid && (q.size() < 2) && !flush;
      cons = (q.size() > 0) && ex_ready;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         if (acc)  q.push_back(id_pay);
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
      id_valid = 1'b1; id_pay = rand_pay();
      tick(); tick();
      n_cmp++;
      if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
      n_cmp++;
      if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready got %0b want 1", id_ready); end
      n_cmp++;
      if (ex_pay !== '0) begin n_fail++; $display("FAIL reset_payload got %h want 0", ex_pay); end
      rst = 1'b0; id_valid = 1'b0;
   endtask

   task automatic test_stream();
      ex_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         id_valid = 1'b1;
         id_pay = mk(8'h10 + 8'(i), 32'(i), 5'(i));
         tick();
         n_cmp++;
         if (ex_valid !== 1'b1 || ex_opv1 !== 32'(i)) begin
            n_fail++; $display("FAIL stream_%0d got v=%0b opv1=%0d want v=1 opv1=%0d", i, ex_valid, ex_opv1, i);
         end
         n_cmp++;
         if (id_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d got %0b want 1", i, id_ready); end
      end
   endtask

   task automatic test_drain();
      id_valid = 1'b0; id_pay = rand_pay(); ex_ready = 1'b1;
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_aluop !== 8'h00) begin
         n_fail++; $display("FAIL drain got v=%0b we=%0b aluop=%h want 0 0 00", ex_valid, ex_we, ex_aluop);
      end
      n_cmp++;
      if (ex_pay !== '0) begin n_fail++; $display("FAIL drain_payload got %h want 0", ex_pay); end
   endtask

   task automatic test_fill_stall();
      ex_ready = 1'b0;
      id_valid = 1'b1; id_pay = mk(8'hA1, 32'hAAAA, 5'd3);
      tick();
      id_pay = mk(8'hB2, 32'hBBBB, 5'd4);
      tick();
      id_pay = mk(8'hC3, 32'hCCCC, 5'd5);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (id_ready !== 1'b0 || ex_valid !== 1'b1 || ex_waddr !== 5'd3 || ex_opv1 !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL full_hold_%0d got rdy=%0b v=%0b waddr=%0d opv1=%h want 0 1 3 aaaa", i, id_ready, ex_valid, ex_waddr, ex_opv1);
         end
         tick();
      end
      id_valid = 1'b0; ex_ready = 1'b1;
      tick();
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_waddr !== 5'd4 || id_ready !== 1'b1) begin
         n_fail++; $display("FAIL emit_b got v=%0b waddr=%0d rdy=%0b want 1 4 1", ex_valid, ex_waddr, id_ready);
      end
      tick();
      n_cmp++;
      if (ex_valid !== 1'b0 || ex_pay !== '0) begin
         n_fail++; $display("FAIL after_b got v=%0b pay=%h want 0 0", ex_valid, ex_pay);
      end
      ex_ready = 1'b0;
   endtask

   task automatic test_flush();
      ex_ready = 1'b0;
      id_valid = 1'b1; id_pay = mk(8'h01, 32'h1111, 5'd1); tick();
      id_pay = mk(8'h02, 32'h2222, 5'd2); tick();
      id_pay = mk(8'h07, 32'h0C0C, 5'd7);
      flush = 1'b1; ex_ready = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if (ex_valid !== 1'b0 || ex_pay !== '0 || id_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush_full got v=%0b pay=%h rdy=%0b want 0 0 1", ex_valid, ex_pay, id_ready);
      end
      id_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (ex_valid !== 1'b0 || ex_waddr === 5'd7) begin
            n_fail++; $display("FAIL flush_leak_%0d got v=%0b waddr=%0d want 0 0", i, ex_valid, ex_waddr);
         end
      end
   endtask

   task automatic test_mid_rst();
      pay_t d;
      ex_ready = 1'b0;
      id_valid = 1'b1; id_pay = mk(8'h31, 32'h3131, 5'd9); tick();
      id_pay = mk(8'h32, 32'h3232, 5'd10); tick();
      rst = 1'b1; id_pay = mk(8'h33, 32'h3333, 5'd11);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (ex_valid !== 1'b0 || ex_pay !== '0 || id_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_%0d got v=%0b pay=%h rdy=%0b want 0 0 1", i, ex_valid, ex_pay, id_ready);
         end
      end
      rst = 1'b0; d = mk(8'h44, 32'h4444, 5'd12); id_pay = d;
      tick();
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_pay !== d) begin
         n_fail++; $display("FAIL resume got v=%0b pay=%h want 1 %h", ex_valid, ex_pay, d);
      end
      id_valid = 1'b0; ex_ready = 1'b1; tick();
   endtask

   task automatic test_random();
      pay_t exp;
      for (int c = 0; c < 400; c++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         id_pay   = rand_pay();
         ex_ready = ($urandom_range(0, 2) != 0) ^ (c[5] & ($urandom_range(0, 1) == 1));
         flush    = ($urandom_range(0, 24) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         tick();
         exp = (q.size() > 0) ? q[0] : '0;
         n_cmp++;
         if (ex_valid !== (q.size() > 0)) begin
            n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, ex_valid, q.size() > 0);
         end
         n_cmp++;
         if (id_ready !== (q.size() < 2)) begin
            n_fail++; $display("FAIL rand_ready cyc %0d got %0b want %0b", c, id_ready, q.size() < 2);
         end
         n_cmp++;
         if (ex_pay !== exp) begin
            n_fail++; $display("FAIL rand_payload cyc %0d got %h want %h", c, ex_pay, exp);
         end
      end
      rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
      tick();
   endtask

`ifdef ID_EX_PERF_EN
   task automatic test_perf();
      rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
      tick();
      rst = 1'b0;
      id_valid = 1'b1; id_pay = rand_pay(); tick();
      id_pay = rand_pay(); tick();
      for (int i = 0; i < 5; i++) tick();
      id_valid = 1'b0; flush = 1'b1;
      tick(); tick();
      flush = 1'b0; ex_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      ex_ready = 1'b0;
      n_cmp++;
      if (perf_stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall got %0d want 5", perf_stall_cnt); end
      n_cmp++;
      if (perf_bubble_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_bubble got %0d want 3", perf_bubble_cnt); end
      n_cmp++;
      if (perf_flush_cnt !== 16'd2) begin n_fail++; $display("FAIL perf_flush got %0d want 2", perf_flush_cnt); end
      force dut.perf_stall_cnt = 32'hFFFF_FFFD;
      #1;
      release dut.perf_stall_cnt;
      id_valid = 1'b1; id_pay = rand_pay(); tick();
      id_pay = rand_pay(); tick();
      for (int i = 0; i < 4; i++) tick();
      id_valid = 1'b0;
      n_cmp++;
      if (perf_stall_cnt !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL perf_stall_sat got %h want ffffffff", perf_stall_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; id_pay = '0;
      test_reset();
      test_stream();
      test_drain();
      test_fill_stall();
      test_flush();
      test_mid_rst();
      test_random();
`ifdef ID_EX_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
